// File: rtl/encoder_read_scheduler_pkg.sv
// rtl/encoder_read_scheduler_pkg.sv - shared types and constants for the encoder read scheduler
// Purpose: state encoding, angle/select widths and default timing values
//          used by the scheduler, its round-robin picker and the I2C interface.
package encoder_read_scheduler_pkg;

  localparam int ANGLE_W                = 12;
  localparam int SEL_W                  = 3;
  localparam int DEFAULT_TIMEOUT_CYCLES = 50000;
  localparam int DEFAULT_GAP_CYCLES     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    GAP   = 2'b11
  } sched_state_t;

endpackage

// File: rtl/encoder_read_scheduler_if.sv
// rtl/encoder_read_scheduler_if.sv - handshake bundle between scheduler and shared I2C master
// Purpose: groups the request/response signals of one shared I2C master.
// Signals:
//   i2c_start    scheduler -> master, request, held until busy seen
//   i2c_sel      scheduler -> master, encoder index for the transaction
//   i2c_busy     master -> scheduler, transaction accepted and running
//   i2c_done     master -> scheduler, one-cycle completion pulse
//   i2c_error    master -> scheduler, NACK/bus error, valid with done
//   i2c_rd_data  master -> scheduler, angle read, valid with done
// Modports: master = scheduler side (drives the request), slave = I2C master side.
interface encoder_read_scheduler_if;
  import encoder_read_scheduler_pkg::*;

  logic               i2c_start;
  logic [SEL_W-1:0]   i2c_sel;
  logic               i2c_busy;
  logic               i2c_done;
  logic               i2c_error;
  logic [ANGLE_W-1:0] i2c_rd_data;

  modport master (
    output i2c_start,
    output i2c_sel,
    input  i2c_busy,
    input  i2c_done,
    input  i2c_error,
    input  i2c_rd_data
  );

  modport slave (
    input  i2c_start,
    input  i2c_sel,
    output i2c_busy,
    output i2c_done,
    output i2c_error,
    output i2c_rd_data
  );

endinterface

// File: rtl/encoder_read_scheduler_rr_pick.sv
// rtl/encoder_read_scheduler_rr_pick.sv - combinational round-robin priority picker
// Purpose: returns the first set bit of mask at or after ptr, searching cyclically.
// Ports:
//   mask   in   NUM_WHEELS  candidate request mask
//   ptr    in   SEL_W       search start index (always < NUM_WHEELS)
//   idx    out  SEL_W       chosen index (0 when nothing is set)
//   valid  out  1           at least one mask bit is set
module encoder_read_scheduler_rr_pick
  import encoder_read_scheduler_pkg::*;
#(
  parameter int NUM_WHEELS = 4
) (
  input  logic [NUM_WHEELS-1:0] mask,
  input  logic [SEL_W-1:0]      ptr,
  output logic [SEL_W-1:0]      idx,
  output logic                  valid
);

  logic [2*NUM_WHEELS-1:0] doubled;
  logic [NUM_WHEELS-1:0]   rot;
  int                      sum;

  // Rotate the mask so bit 0 corresponds to ptr; the lowest set bit of the
  // rotated mask is then the closest requester at or after ptr.
  always_comb begin
    doubled = {mask, mask} >> ptr;
    rot     = doubled[NUM_WHEELS-1:0];
    idx     = '0;
    valid   = 1'b0;
    sum     = 0;
    // Descending scan: the smallest offset is written last and wins.
    for (int i = NUM_WHEELS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = int'(ptr) + i;
        if (sum >= NUM_WHEELS) begin
          sum = sum - NUM_WHEELS;
        end
        idx   = SEL_W'(sum);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_read_scheduler.sv
// rtl/encoder_read_scheduler.sv - round-robin angle read scheduler over one shared I2C master
// Purpose: issues encoder angle reads in round-robin order, captures each
//          12-bit result into a per-wheel slot and strobes a per-wheel done.
// Ports:
//   clock          in   1                   main clock
//   reset          in   1                   synchronous active-high reset
//   wheel_enable   in   NUM_WHEELS          per-wheel read request mask
//   clear_errors   in   NUM_WHEELS          write-1-to-clear for sticky error bits
//   i2c            if   master modport      shared I2C master handshake
//   current_angle  out  12*NUM_WHEELS       angle slots, wheel w at [12w+11:12w]
//   rd_done        out  NUM_WHEELS          one-cycle strobe when slot w updates
//   rd_error       out  NUM_WHEELS          sticky NACK flag per wheel
//   rd_timeout     out  NUM_WHEELS          sticky timeout flag per wheel
//   active         out  1                   transaction outstanding (ISSUE/WAIT)
module encoder_read_scheduler
  import encoder_read_scheduler_pkg::*;
#(
  parameter int NUM_WHEELS     = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_WHEELS-1:0]         wheel_enable,
  input  logic [NUM_WHEELS-1:0]         clear_errors,
  encoder_read_scheduler_if.master      i2c,
  output logic [ANGLE_W*NUM_WHEELS-1:0] current_angle,
  output logic [NUM_WHEELS-1:0]         rd_done,
  output logic [NUM_WHEELS-1:0]         rd_error,
  output logic [NUM_WHEELS-1:0]         rd_timeout,
  output logic                          active
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);

  sched_state_t          state;
  logic [SEL_W-1:0]      cur;
  logic [SEL_W-1:0]      rr_ptr;
  logic [SEL_W-1:0]      pick_idx;
  logic                  pick_valid;
  logic [15:0]           tmo_cnt;
  logic [15:0]           gap_cnt;
  logic [NUM_WHEELS-1:0] cur_oh;

  assign cur_oh = NUM_WHEELS'(1) << cur;

  encoder_read_scheduler_rr_pick #(
    .NUM_WHEELS (NUM_WHEELS)
  ) u_rr_pick (
    .mask  (wheel_enable),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cur           <= '0;
      rr_ptr        <= '0;
      tmo_cnt       <= '0;
      gap_cnt       <= '0;
      i2c.i2c_start <= 1'b0;
      i2c.i2c_sel   <= '0;
      current_angle <= '0;
      rd_done       <= '0;
      rd_error      <= '0;
      rd_timeout    <= '0;
      active        <= 1'b0;
    end else begin
      rd_done    <= '0;
      // Clears apply every cycle; a set on the same wheel below overrides them.
      rd_error   <= rd_error & ~clear_errors;
      rd_timeout <= rd_timeout & ~clear_errors;

      case (state)
        IDLE: begin
          if (pick_valid) begin
            cur           <= pick_idx;
            i2c.i2c_sel   <= pick_idx;
            i2c.i2c_start <= 1'b1;
            active        <= 1'b1;
            tmo_cnt       <= '0;
            state         <= ISSUE;
          end
        end

        ISSUE, WAIT: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          // A done seen before busy still counts as completion.
          if (i2c.i2c_done) begin
            if (i2c.i2c_error) begin
              rd_error <= (rd_error & ~clear_errors) | cur_oh;
            end else begin
              rd_done <= cur_oh;
              for (int w = 0; w < NUM_WHEELS; w++) begin
                if (cur_oh[w]) begin
                  current_angle[w*ANGLE_W +: ANGLE_W] <= i2c.i2c_rd_data;
                end
              end
            end
            i2c.i2c_start <= 1'b0;
            active        <= 1'b0;
            gap_cnt       <= '0;
            state         <= GAP;
          end else if (tmo_cnt == TIMEOUT_LAST) begin
            rd_timeout    <= (rd_timeout & ~clear_errors) | cur_oh;
            i2c.i2c_start <= 1'b0;
            active        <= 1'b0;
            gap_cnt       <= '0;
            state         <= GAP;
          end else if (state == ISSUE && i2c.i2c_busy) begin
            i2c.i2c_start <= 1'b0;
            state         <= WAIT;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            rr_ptr <= (cur == SEL_W'(NUM_WHEELS - 1)) ? '0 : cur + 1'b1;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_read_scheduler.sv
// tb/tb_encoder_read_scheduler.sv - self-checking bench for encoder_read_scheduler
module tb_encoder_read_scheduler;
  import encoder_read_scheduler_pkg::*;

  localparam int NW  = 4;
  localparam int TMO = 100;
  localparam int GP  = 4;
  localparam int DLY = 20;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NW-1:0]         wheel_enable;
  logic [NW-1:0]         clear_errors;
  logic [ANGLE_W*NW-1:0] current_angle;
  logic [NW-1:0]         rd_done;
  logic [NW-1:0]         rd_error;
  logic [NW-1:0]         rd_timeout;
  logic                  active;

  encoder_read_scheduler_if i2c_bus ();

  encoder_read_scheduler #(
    .NUM_WHEELS     (NW),
    .TIMEOUT_CYCLES (TMO),
    .GAP_CYCLES     (GP)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .wheel_enable  (wheel_enable),
    .clear_errors  (clear_errors),
    .i2c           (i2c_bus),
    .current_angle (current_angle),
    .rd_done       (rd_done),
    .rd_error      (rd_error),
    .rd_timeout    (rd_timeout),
    .active        (active)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // I2C master model: busy the cycle after start, done DLY cycles later.
  logic [NW-1:0] resp_err    = '0;
  logic [NW-1:0] resp_silent = '0;
  int            rw;

  initial begin
    i2c_bus.i2c_busy    = 1'b0;
    i2c_bus.i2c_done    = 1'b0;
    i2c_bus.i2c_error   = 1'b0;
    i2c_bus.i2c_rd_data = '0;
    forever begin
      @(negedge clock);
      if (i2c_bus.i2c_start && !reset) begin
        rw = int'(i2c_bus.i2c_sel);
        @(posedge clock); #1;
        i2c_bus.i2c_busy = 1'b1;
        if (resp_silent[rw]) begin
          for (int c = 0; c < 1000 && active; c++) @(negedge clock);
          @(posedge clock); #1;
          i2c_bus.i2c_busy = 1'b0;
        end else begin
          repeat (DLY) @(posedge clock);
          #1;
          i2c_bus.i2c_done    = 1'b1;
          i2c_bus.i2c_error   = resp_err[rw];
          i2c_bus.i2c_rd_data = resp_err[rw] ? 12'hFFF : 12'h100 + 12'(rw);
          @(posedge clock); #1;
          i2c_bus.i2c_done    = 1'b0;
          i2c_bus.i2c_error   = 1'b0;
          i2c_bus.i2c_busy    = 1'b0;
          i2c_bus.i2c_rd_data = '0;
        end
      end
    end
  end

  // Monitor: issue order, rd_done counts and the one-cycle done latency.
  logic [SEL_W-1:0] seq_q[$];
  int               done_cnt[NW];
  logic             prev_start = 1'b0;
  logic             prev_done  = 1'b0;
  logic             prev_err   = 1'b0;
  logic [SEL_W-1:0] prev_sel   = '0;

  always @(negedge clock) begin
    if (reset) begin
      seq_q.delete();
      for (int w = 0; w < NW; w++) done_cnt[w] = 0;
    end else begin
      if (i2c_bus.i2c_start && !prev_start) seq_q.push_back(i2c_bus.i2c_sel);
      if (rd_done != '0) begin
        check("rd_done_timing", 64'(rd_done),
              64'((prev_done && !prev_err) ? (NW'(1) << prev_sel) : NW'(0)));
        for (int w = 0; w < NW; w++) if (rd_done[w]) done_cnt[w]++;
      end
    end
    prev_start = i2c_bus.i2c_start;
    prev_done  = i2c_bus.i2c_done;
    prev_err   = i2c_bus.i2c_error;
    prev_sel   = i2c_bus.i2c_sel;
  end

  task automatic do_reset();
    @(negedge clock);
    reset        = 1'b1;
    wheel_enable = '0;
    clear_errors = '0;
    repeat (3) @(negedge clock);
    check("rst_start", 64'(i2c_bus.i2c_start), 64'd0);
    check("rst_sel", 64'(i2c_bus.i2c_sel), 64'd0);
    check("rst_active", 64'(active), 64'd0);
    check("rst_angle", 64'(current_angle), 64'd0);
    check("rst_flags", 64'({rd_done, rd_error, rd_timeout}), 64'd0);
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (active && c < 2000) begin
      @(negedge clock);
      c++;
    end
    check("idle_bound", 64'(active), 64'd0);
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_start_sel(input logic [SEL_W-1:0] s);
    int c = 0;
    while (!(i2c_bus.i2c_start && i2c_bus.i2c_sel == s) && c < 2000) begin
      @(negedge clock);
      c++;
    end
    check("start_bound", 64'(i2c_bus.i2c_start && i2c_bus.i2c_sel == s), 64'd1);
  endtask

  typedef struct {
    logic [NW-1:0] mask;
    int            nreads;
    logic [14:0]   seq;
    logic [47:0]   slots;
    logic [15:0]   cnts;
  } vec_t;

  vec_t vecs[5];

  initial begin
    reset        = 1'b1;
    wheel_enable = '0;
    clear_errors = '0;

    vecs[0] = '{4'b1111, 5, {3'd0, 3'd3, 3'd2, 3'd1, 3'd0},
                {12'h103, 12'h102, 12'h101, 12'h100}, {4'd1, 4'd1, 4'd1, 4'd2}};
    vecs[1] = '{4'b0101, 4, {3'd0, 3'd2, 3'd0, 3'd2, 3'd0},
                {12'h000, 12'h102, 12'h000, 12'h100}, {4'd0, 4'd2, 4'd0, 4'd2}};
    vecs[2] = '{4'b1000, 2, {3'd0, 3'd0, 3'd0, 3'd3, 3'd3},
                {12'h103, 12'h000, 12'h000, 12'h000}, {4'd2, 4'd0, 4'd0, 4'd0}};
    vecs[3] = '{4'b0110, 3, {3'd0, 3'd0, 3'd1, 3'd2, 3'd1},
                {12'h000, 12'h102, 12'h101, 12'h000}, {4'd0, 4'd1, 4'd2, 4'd0}};
    vecs[4] = '{4'b1010, 3, {3'd0, 3'd0, 3'd1, 3'd3, 3'd1},
                {12'h103, 12'h000, 12'h101, 12'h000}, {4'd1, 4'd0, 4'd2, 4'd0}};

    for (int k = 0; k < 5; k++) begin
      int c = 0;
      do_reset();
      wheel_enable = vecs[k].mask;
      while (seq_q.size() < vecs[k].nreads && c < 3000) begin
        @(negedge clock);
        c++;
      end
      wheel_enable = '0;
      wait_idle();
      check($sformatf("v%0d_nreads", k), 64'(seq_q.size()), 64'(vecs[k].nreads));
      for (int i = 0; i < vecs[k].nreads && i < seq_q.size(); i++)
        check($sformatf("v%0d_seq%0d", k, i), 64'(seq_q[i]), 64'(vecs[k].seq[3*i +: 3]));
      check($sformatf("v%0d_slots", k), 64'(current_angle), 64'(vecs[k].slots));
      for (int w = 0; w < NW; w++)
        check($sformatf("v%0d_done_cnt%0d", k, w), 64'(done_cnt[w]), 64'(vecs[k].cnts[4*w +: 4]));
    end

    // NACK on wheel 2 after a clean read: slot kept, sticky error, W1C clear.
    begin
      int c = 0;
      do_reset();
      wheel_enable = 4'b0100;
      while (done_cnt[2] < 1 && c < 500) begin @(negedge clock); c++; end
      resp_err[2] = 1'b1;
      c = 0;
      while (!rd_error[2] && c < 500) begin @(negedge clock); c++; end
      wheel_enable = '0;
      check("err_slot2", 64'(current_angle[35:24]), 64'h102);
      check("err_rd_error", 64'(rd_error), 64'b0100);
      check("err_no_done", 64'(done_cnt[2]), 64'd1);
      wait_idle();
      resp_err[2]  = 1'b0;
      clear_errors = 4'b0100;
      @(negedge clock);
      clear_errors = '0;
      check("err_cleared", 64'(rd_error), 64'd0);
    end

    // Wheel 1 never answers: timeout after exactly TMO cycles, then wheel 2.
    do_reset();
    resp_silent  = 4'b0010;
    wheel_enable = 4'b1111;
    wait_start_sel(3'd1);
    repeat (TMO - 1) @(negedge clock);
    check("tmo_not_yet", 64'({rd_timeout, active}), 64'b00001);
    @(negedge clock);
    check("tmo_flag", 64'(rd_timeout), 64'b0010);
    check("tmo_start", 64'({i2c_bus.i2c_start, active}), 64'd0);
    repeat (GP) @(negedge clock);
    check("tmo_gap_idle", 64'(i2c_bus.i2c_start), 64'd0);
    @(negedge clock);
    check("tmo_next_wheel", 64'({i2c_bus.i2c_start, i2c_bus.i2c_sel}), 64'({1'b1, 3'd2}));
    check("tmo_no_done1", 64'(done_cnt[1]), 64'd0);
    wheel_enable = '0;
    wait_idle();
    resp_silent = '0;

    // Reset while waiting on wheel 2; the stale done must be ignored.
    begin
      int c = 0;
      do_reset();
      wheel_enable = 4'b1111;
      wait_start_sel(3'd2);
      while (!(i2c_bus.i2c_busy && !i2c_bus.i2c_start) && c < 100) begin @(negedge clock); c++; end
      reset        = 1'b1;
      wheel_enable = '0;
      @(negedge clock);
      check("rw_reset_outs", 64'({i2c_bus.i2c_start, active, rd_done}), 64'd0);
      check("rw_reset_angle", 64'(current_angle), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      c = 0;
      while (!i2c_bus.i2c_done && c < 100) begin @(negedge clock); c++; end
      check("rw_stale_seen", 64'(i2c_bus.i2c_done), 64'd1);
      repeat (2) @(negedge clock);
      check("rw_no_done", 64'(done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3]), 64'd0);
      check("rw_quiet", 64'({current_angle, i2c_bus.i2c_start, active}), 64'd0);
      wheel_enable = 4'b1111;
      c = 0;
      while (!i2c_bus.i2c_start && c < 100) begin @(negedge clock); c++; end
      check("rw_first_wheel0", 64'({i2c_bus.i2c_start, i2c_bus.i2c_sel}), 64'({1'b1, 3'd0}));
      wheel_enable = '0;
      wait_idle();
    end

    // Clear on the very edge rd_timeout[3] gets set: the set wins.
    do_reset();
    resp_silent  = 4'b1000;
    wheel_enable = 4'b1000;
    wait_start_sel(3'd3);
    wheel_enable = '0;
    repeat (TMO - 1) @(negedge clock);
    clear_errors = 4'b1000;
    @(negedge clock);
    clear_errors = '0;
    check("sc_set_wins", 64'(rd_timeout), 64'b1000);
    @(negedge clock);
    check("sc_sticky", 64'(rd_timeout), 64'b1000);
    clear_errors = 4'b1000;
    @(negedge clock);
    clear_errors = '0;
    check("sc_cleared", 64'(rd_timeout), 64'd0);
    wait_idle();
    resp_silent = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
